// File: rtl/prio_encoder_scan.sv
// rtl/prio_encoder_scan.sv - clocked priority scanner emitting set-bit indices of a request vector
//
// Accepts an N-bit request vector y over an in_valid/in_ready handshake and
// emits one beat per cycle over out_valid/out_ready: the index a of each set
// bit in priority order (PRIO_MSB=1: highest bit first), with qualifiers
// last (final beat of the vector), zero (vector was all-zero) and cnt
// (popcount of the vector, held for all its beats).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid, in_ready  input handshake (in_ready combinational from out_ready)
//   y                   request vector
//   out_valid, out_ready output handshake
//   a, last, zero, cnt  current beat and qualifiers
module prio_encoder_scan #(
    parameter int N        = 8,
    parameter int PRIO_MSB = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(N)-1:0]   a,
    output logic                   last,
    output logic                   zero,
    output logic [$clog2(N):0]     cnt
);

    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   pending;
    logic [W-1:0]   idx;
    logic           single;
    logic           accept;
    logic           consume;

    function automatic logic [W:0] popcount(input logic [N-1:0] v);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + (W+1)'(v[i]);
        end
        return c;
    endfunction

    // Priority select over pending; the later loop iteration wins, so the
    // loop direction decides which end of the vector has priority.
    always_comb begin
        idx = '0;
        if (PRIO_MSB != 0) begin
            for (int i = 0; i < N; i++) begin
                if (pending[i]) idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pending[i]) idx = W'(i);
            end
        end
    end

    // At most one bit set: clearing the lowest set bit leaves nothing.
    assign single    = ((pending & (pending - N'(1))) == '0);

    assign out_valid = (state == SCAN);
    assign last      = out_valid && single;
    assign a         = idx;
    assign in_ready  = (state == IDLE) || (out_ready && last);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = SCAN;
        end else if (consume && last) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            cnt     <= '0;
            zero    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pending <= y;
                cnt     <= popcount(y);
                zero    <= (y == '0);
            end else if (consume && !last) begin
                pending <= pending & ~(N'(1) << idx);
            end
            // On the final beat without a reload, pending is left untouched
            // so a keeps showing the last emitted index while idle.
        end
    end

endmodule

// File: tb/tb_prio_encoder_scan.sv
// tb/tb_prio_encoder_scan.sv - self-checking bench for prio_encoder_scan (MSB- and LSB-first instances)
module tb_prio_encoder_scan;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] y;
    logic         out_ready;

    logic         in_ready_m, out_valid_m, last_m, zero_m;
    logic [W-1:0] a_m;
    logic [W:0]   cnt_m;
    logic         in_ready_l, out_valid_l, last_l, zero_l;
    logic [W-1:0] a_l;
    logic [W:0]   cnt_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prio_encoder_scan #(.N(N), .PRIO_MSB(1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m), .y(y),
        .out_valid(out_valid_m), .out_ready(out_ready), .a(a_m), .last(last_m),
        .zero(zero_m), .cnt(cnt_m)
    );

    prio_encoder_scan #(.N(N), .PRIO_MSB(0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l), .y(y),
        .out_valid(out_valid_l), .out_ready(out_ready), .a(a_l), .last(last_l),
        .zero(zero_l), .cnt(cnt_l)
    );

    // Reference model: the outstanding beats of the current vector as
    // index queues (one per priority order), plus the held qualifiers.
    int q_msb[$];
    int q_lsb[$];
    int held_a_msb = 0;
    int held_a_lsb = 0;
    int exp_cnt    = 0;
    int exp_zero   = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic load_vector(input logic [N-1:0] v);
        q_msb.delete();
        q_lsb.delete();
        exp_cnt = 0;
        for (int i = N - 1; i >= 0; i--) if (v[i]) q_msb.push_back(i);
        for (int i = 0; i < N; i++) if (v[i]) q_lsb.push_back(i);
        exp_cnt = q_msb.size();
        exp_zero = (v == '0) ? 1 : 0;
        if (v == '0) begin
            q_msb.push_back(0);
            q_lsb.push_back(0);
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model at
    // the rising edge, then leave 1 time unit for the caller to drive.
    task automatic cycle();
        bit ev, elast, eready, fire_in, fire_out;
        @(negedge clk);
        ev     = (q_msb.size() != 0);
        elast  = (q_msb.size() == 1);
        eready = !ev || (out_ready && elast);
        check("out_valid_msb", int'(out_valid_m), int'(ev));
        check("out_valid_lsb", int'(out_valid_l), int'(ev));
        check("in_ready_msb", int'(in_ready_m), int'(eready));
        check("in_ready_lsb", int'(in_ready_l), int'(eready));
        check("a_msb", int'(a_m), ev ? q_msb[0] : held_a_msb);
        check("a_lsb", int'(a_l), ev ? q_lsb[0] : held_a_lsb);
        check("cnt_msb", int'(cnt_m), exp_cnt);
        check("cnt_lsb", int'(cnt_l), exp_cnt);
        check("zero_msb", int'(zero_m), exp_zero);
        check("zero_lsb", int'(zero_l), exp_zero);
        if (ev) begin
            check("last_msb", int'(last_m), int'(elast));
            check("last_lsb", int'(last_l), int'(elast));
        end
        fire_in  = in_valid && eready;
        fire_out = ev && out_ready;
        @(posedge clk);
        if (!rst_n) begin
            q_msb.delete();
            q_lsb.delete();
            held_a_msb = 0;
            held_a_lsb = 0;
            exp_cnt    = 0;
            exp_zero   = 0;
        end else begin
            if (fire_out) begin
                held_a_msb = q_msb.pop_front();
                held_a_lsb = q_lsb.pop_front();
            end
            if (fire_in) load_vector(y);
        end
        #1;
    endtask

    task automatic send_one(input logic [N-1:0] v);
        in_valid = 1'b1;
        y        = v;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        y         = '0;
        out_ready = 1'b1;
        repeat (2) cycle();
        check("reset_last_msb", int'(last_m), 0);
        rst_n = 1'b1;

        send_one(8'h01);
        repeat (2) cycle();

        send_one(8'h84);
        repeat (3) cycle();

        send_one(8'h00);
        repeat (2) cycle();

        out_ready = 1'b0;
        send_one(8'h84);
        repeat (3) cycle();
        out_ready = 1'b1;
        repeat (3) cycle();

        // Back-to-back: second vector accepted on the single beat of the first.
        in_valid = 1'b1;
        y        = 8'h08;
        cycle();
        y        = 8'h30;
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();

        // Reset in the middle of a scan.
        send_one(8'hFF);
        repeat (2) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        send_one(8'h01);
        repeat (2) cycle();

        // Randomized traffic with sparse, dense and zero vectors.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0:       y = '0;
                1:       y = N'(1) << $urandom_range(0, N - 1);
                2:       y = '1;
                default: y = N'($urandom);
            endcase
            rst_n = ($urandom_range(0, 199) != 0);
            cycle();
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (12) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
